// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-read-port, 1-cycle-latency instruction memory.
// Port 0 is the fetch stage, port 1 the debug/loader; responses return one cycle after grant.
module imem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp0_error,
  input  logic              flush0,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  output logic              resp1_error,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_inst,
  input  logic              mem_error
);

  logic              gnt0, gnt1;
  logic              rr_ptr;      // port that wins the next tie
  logic              pend_valid, pend_port, pend_err;
  logic [1:0]        rsp_vld;
  logic [1:0][DATA_W-1:0] dat_q;
  logic [1:0]        err_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (FAIR != 0 && rr_ptr) gnt1 = 1'b1;
        else                     gnt0 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mem_addr   = gnt0 ? req0_addr : (gnt1 ? req1_addr : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      pend_err   <= 1'b0;
      rr_ptr     <= 1'b0;
    end else begin
      pend_valid <= gnt0 | gnt1;
      pend_port  <= gnt1;
      pend_err   <= mem_error;
      if (gnt0 | gnt1) rr_ptr <= gnt0;
    end
  end

  // rst gates the pulse so an in-flight response dies in the reset cycle itself
  assign rsp_vld[0] = !rst && pend_valid && !pend_port && !flush0;
  assign rsp_vld[1] = !rst && pend_valid &&  pend_port;

  for (genvar p = 0; p < 2; p++) begin : g_port
    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q[p] <= '0;
        err_q[p] <= 1'b0;
      end else if (rsp_vld[p]) begin
        dat_q[p] <= mem_inst;
        err_q[p] <= pend_err;
      end
    end
  end

  assign resp0_valid = rsp_vld[0];
  assign resp1_valid = rsp_vld[1];
  assign resp0_data  = rsp_vld[0] ? mem_inst : dat_q[0];
  assign resp1_data  = rsp_vld[1] ? mem_inst : dat_q[1];
  assign resp0_error = rsp_vld[0] ? pend_err : err_q[0];
  assign resp1_error = rsp_vld[1] ? pend_err : err_q[1];

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-read-port, 1-cycle-latency instruction memory between two requesters: port 0 (IF fetch stage) and port 1 (debug/loader read port).
- Arbitrates one request per cycle and drives the memory address combinationally.
- Captures the memory's combinational address-error flag at grant time, then routes the registered read data and the error back to the granted requester one cycle later.
- Supports a fetch flush that cancels an in-flight port-0 response on branch redirect.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, instruction word width.
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  fetch request valid.
- req0_addr  in  ADDR_W  fetch byte address.
- req0_ready  out  1  fetch request granted this cycle.
- resp0_valid  out  1  fetch response pulse.
- resp0_data  out  DATA_W  fetched instruction.
- resp0_error  out  1  fetch address fault.
- flush0  in  1  cancel in-flight fetch response.
- req1_valid  in  1  debug request valid.
- req1_addr  in  ADDR_W  debug byte address.
- req1_ready  out  1  debug request granted.
- resp1_valid  out  1  debug response pulse.
- resp1_data  out  DATA_W  debug read data.
- resp1_error  out  1  debug address fault.
- mem_addr  out  ADDR_W  address to instruction memory.
- mem_inst  in  DATA_W  registered memory data, valid the cycle after the address.
- mem_error  in  1  combinational fault for the current mem_addr (misaligned or out of range).

Behaviour:
- Reset (rst=1 at posedge):
  - resp0_valid, resp1_valid, resp0_error, resp1_error = 0; resp*_data = 0.
  - Round-robin pointer set so port 0 has next priority.
  - Pending state cleared; any in-flight response is dropped, so no resp pulse appears in the cycle after reset deasserts.
  - While rst=1, req0_ready = req1_ready = 0.
- Grant (combinational, cycle N):
  - Only one request active: that port is granted.
  - Both active: FAIR=1 grants the port not granted most recently; FAIR=0 always grants port 0.
  - reqX_ready=1 only for the granted port; the request is consumed only when valid and ready are both 1.
  - mem_addr = granted port's address; 0 when nothing is granted.
- Pending register (updated at posedge ending cycle N):
  - pend_valid = grant occurred.
  - pend_port = granted port index.
  - pend_err = mem_error sampled in cycle N.
  - Round-robin pointer updates only on a grant.
- Response (cycle N+1):
  - If pend_valid, resp{pend_port}_valid = 1, resp_data = mem_inst, resp_error = pend_err.
  - The response is registered-path aligned: data comes straight from mem_inst, and valid/error come from the pending register.
  - Responses are single-cycle pulses with no backpressure; requesters must accept them.
  - Non-selected port's resp_valid = 0; its data/error hold their previous values.
- Throughput: one grant per cycle, fully pipelined; back-to-back grants to the same or alternating ports are legal.
- flush0:
  - flush0=1 in cycle N+1 while pend_port=0 suppresses resp0_valid in that cycle.
  - A request presented on port 0 in the same cycle is still arbitrated normally; the new PC fetch is not blocked.
  - flush0 has no effect on port-1 responses.
- Errors:
  - Data is still returned alongside an error, but the consumer ignores it.
  - A faulting request does not stall arbitration.
- Simultaneous flush0 and rst: rst dominates.
- Address is forwarded unmodified; alignment and range checks remain in the memory.

Test Plan:
- Fetch-only stream: req0 at 0x0,0x4,0x8 on consecutive cycles -> req0_ready=1 each cycle; resp0_valid on cycles 1..3 with mem[0],mem[1],mem[2]; resp0_error=0.
- Contention, FAIR=1: both valid for 4 cycles, req0=0x10, req1=0x20 -> grants alternate 0,1,0,1; resp data matches mem[4]/mem[8] on the matching port the next cycle.
- Contention, FAIR=0: both valid for 3 cycles -> req1_ready=0 throughout; port 1 is granted in the first cycle req0_valid=0.
- Fault: req1 at 0x1002 -> resp1_valid=1 with resp1_error=1 the next cycle; the following req1 at 0x0 returns error=0.
- Flush: fetch 0x40 granted in cycle N, flush0=1 in N+1 together with req0=0x80 -> no resp0 in N+1; resp0 in N+2 = mem[32].
- Reset mid-flight: grant req0 in cycle N, rst=1 in N+1 -> resp0_valid=0 in N+1 and N+2; all outputs at reset values; first post-reset grant goes to port 0 when both ports request.
